int_gateway: RTL and testbench

INT_GATEWAY -- requirements
Module: int_gateway

---
 rtl/int_gateway_pkg.sv | 12 +
 rtl/int_gateway_if.sv | 25 ++
 rtl/int_edge_cnt.sv | 44 ++++
 rtl/int_gateway.sv | 88 ++++++++
 tb/tb_int_gateway.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/int_gateway_pkg.sv
// Shared types and defaults for the interrupt gateway.
package int_pkg;

    localparam int unsigned CntWDefault = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_CLAIM = 2'd1,
        IN_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/int_gateway_if.sv
// Source-side and target-side signals of one interrupt gateway.
interface int_gateway_if import int_pkg::*; #(
    parameter int unsigned CNT_W = CntWDefault
) ();

    logic             irq_src;
    logic             edge_sel;
    logic             enable;
    logic             claim;
    logic             complete;
    logic             gate;
    logic             busy;
    logic [CNT_W-1:0] edge_cnt;

    modport master (
        output irq_src, edge_sel, enable, claim, complete,
        input  gate, busy, edge_cnt
    );

    modport slave (
        input  irq_src, edge_sel, enable, claim, complete,
        output gate, busy, edge_cnt
    );

endinterface

// File: rtl/int_edge_cnt.sv
// Rising-edge detector feeding a saturating count of edges awaiting forwarding.
module int_edge_cnt import int_pkg::*; #(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irq_src_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             edge_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             irq_d_q, irq_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    always_comb begin
        irq_d_d = irq_src_i;
        rise    = irq_src_i & ~irq_d_q;
        cnt_d   = cnt_q;
        // An edge consumed by a same-cycle forward never touches the count.
        if (rise && !dec_i) begin
            if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end else if (!rise && dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            irq_d_q <= irq_d_d;
            cnt_q   <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign edge_o  = rise;

endmodule

// File: rtl/int_gateway.sv
// Interrupt gateway: forwards one request at a time and waits for claim/complete.
// Edge-triggered mode and its counter exist only when INT_GW_EDGE_EN is defined.
module int_gateway import int_pkg::*; #(
    parameter int unsigned CNT_W = CntWDefault
) (
    input logic          clk,
    input logic          rst,
    int_gateway_if.slave bus
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             sel;
    logic             edge_req;

    assign edge_req = sel & ((cnt != '0) | rise);

`ifdef INT_GW_EDGE_EN
    logic dec;

    assign sel = bus.edge_sel;
    assign dec = (state_q == IDLE) & bus.enable & edge_req;

    int_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk       (clk),
        .rst       (rst),
        .irq_src_i (bus.irq_src),
        .dec_i     (dec),
        .count_o   (cnt),
        .edge_o    (rise)
    );
`else
    assign sel  = 1'b0;
    assign cnt  = '0;
    assign rise = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    if (sel) begin
                        if (edge_req) begin
                            state_d = WAIT_CLAIM;
                            mode_d  = 1'b1;
                        end
                    end else if (bus.irq_src) begin
                        state_d = WAIT_CLAIM;
                        mode_d  = 1'b0;
                    end
                end
            end
            WAIT_CLAIM: begin
                // Claim beats a retracted level; complete is meaningless here.
                if (bus.claim) begin
                    state_d = IN_SERVICE;
                end else if (!mode_q && !bus.irq_src) begin
                    state_d = IDLE;
                end
            end
            IN_SERVICE: begin
                if (bus.complete) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.gate     = (state_q == WAIT_CLAIM);
    assign bus.busy     = (state_q != IDLE);
    assign bus.edge_cnt = cnt;

endmodule

// File: tb/tb_int_gateway.sv
// Self-checking bench for int_gateway: vector table, directed corner cases, random vs model.
module tb_int_gateway;

    localparam int unsigned CNT_W = 2;
    localparam int CntMax = 3;
`ifdef INT_GW_EDGE_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif
    localparam int E = EdgeEn ? 1 : 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_gateway_if #(.CNT_W(CNT_W)) bus ();

    int_gateway #(
        .CNT_W (CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec  = 0;
    int nfail = 0;

    // Reference: one request slot, one service slot, a bag of pending edges.
    bit m_prev, m_req, m_svc, m_mode_edge;
    int m_pend;

    function automatic void model_step();
        bit rise;
        int fwd;
        rise   = EdgeEn && bus.irq_src && !m_prev;
        fwd    = 0;
        m_prev = bus.irq_src;
        if (rst) begin
            m_prev = 0; m_req = 0; m_svc = 0; m_mode_edge = 0; m_pend = 0;
            return;
        end
        if (!m_req && !m_svc) begin
            if (bus.enable) begin
                if (EdgeEn && bus.edge_sel) begin
                    if (m_pend > 0 || rise) begin
                        m_req = 1; m_mode_edge = 1; fwd = 1;
                    end
                end else if (bus.irq_src) begin
                    m_req = 1; m_mode_edge = 0;
                end
            end
        end else if (m_req) begin
            if (bus.claim) begin
                m_req = 0; m_svc = 1;
            end else if (!m_mode_edge && !bus.irq_src) begin
                m_req = 0;
            end
        end else if (bus.complete) begin
            m_svc = 0;
        end
        m_pend = m_pend + int'(rise) - fwd;
        if (m_pend > CntMax) m_pend = CntMax;
    endfunction

    // s = {rst, irq_src, edge_sel, enable, claim, complete}
    task automatic drive(input logic [5:0] s);
        rst          = s[5];
        bus.irq_src  = s[4];
        bus.edge_sel = s[3];
        bus.enable   = s[2];
        bus.claim    = s[1];
        bus.complete = s[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0] stim;
        logic [1:0] gb;   // {gate, busy}
        int         c;
    } vec_t;

    vec_t tbl [19];

    initial begin
        bit r, irq, sel, en, clm, cmp, c, p;
        int nfwd;

        tbl = '{
            '{6'b100100, 2'b00, 0},     // reset
            '{6'b010100, 2'b11, E},     // level request -> gate next cycle
            '{6'b010100, 2'b11, E},
            '{6'b010110, 2'b01, E},     // claim -> in service
            '{6'b000110, 2'b01, E},     // claim ignored in service
            '{6'b000101, 2'b00, E},     // complete
            '{6'b010100, 2'b11, 2 * E},
            '{6'b000100, 2'b00, 2 * E}, // level retracted
            '{6'b010111, 2'b11, 3 * E}, // claim/complete ignored in idle
            '{6'b000111, 2'b01, 3 * E}, // claim beats drop and complete
            '{6'b010101, 2'b00, 3 * E}, // complete, edge saturates
            '{6'b010100, 2'b11, 3 * E}, // re-forward with no dead cycle
            '{6'b010110, 2'b01, 3 * E},
            '{6'b000101, 2'b00, 3 * E},
            '{6'b010000, 2'b00, 3 * E}, // enable low blocks forwarding
            '{6'b110100, 2'b00, 0},     // reset wins over request
            '{6'b010100, 2'b11, E},
            '{6'b001100, 2'b00, E},     // mode latched as level: retract
            '{6'b100100, 2'b00, 0}
        };

        drive(6'b100000);
        tick();
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].stim);
            tick();
            chk($sformatf("tbl%0d.gate", i), 32'(bus.gate), 32'(tbl[i].gb[1]));
            chk($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'(tbl[i].gb[0]));
            chk($sformatf("tbl%0d.cnt", i), 32'(bus.edge_cnt), tbl[i].c);
        end

`ifdef INT_GW_EDGE_EN
        // Edge burst while in service, then drained over claim/complete rounds.
        drive(6'b101100); tick();
        drive(6'b011100); tick();
        chk("burst.fwd.gate", 32'(bus.gate), 1);
        chk("burst.fwd.cnt", 32'(bus.edge_cnt), 0);
        drive(6'b001110); tick();
        chk("burst.claim.busy", 32'(bus.busy), 1);
        for (int k = 0; k < 3; k++) begin
            drive(6'b011100); tick();
            drive(6'b001100); tick();
        end
        chk("burst.cnt3", 32'(bus.edge_cnt), 3);
        chk("burst.busy", 32'(bus.busy), 1);
        drive(6'b001101); tick();
        chk("burst.done.busy", 32'(bus.busy), 0);
        drive(6'b001100); tick();
        chk("burst.refwd.gate", 32'(bus.gate), 1);
        chk("burst.refwd.cnt", 32'(bus.edge_cnt), 2);
        for (int k = 0; k < 3; k++) begin
            drive(6'b001110); tick();
            drive(6'b001101); tick();
            drive(6'b001100); tick();
            chk($sformatf("round%0d.gate", k), 32'(bus.gate), (k < 2) ? 1 : 0);
            chk($sformatf("round%0d.cnt", k), 32'(bus.edge_cnt), (k == 0) ? 1 : 0);
        end
        chk("burst.end.busy", 32'(bus.busy), 0);

        // Saturation with enable low, then exactly CntMax forwards.
        drive(6'b101000); tick();
        for (int k = 0; k < 5; k++) begin
            drive(6'b011000); tick();
            drive(6'b001000); tick();
        end
        chk("sat.cnt", 32'(bus.edge_cnt), 3);
        nfwd = 0;
        for (int k = 0; k < 40; k++) begin
            c = bus.gate;
            p = bus.busy & ~bus.gate;
            drive({1'b0, 1'b0, 1'b1, 1'b1, c, p});
            tick();
            if (c) nfwd++;
        end
        chk("sat.fwds", nfwd, 3);
        chk("sat.cnt0", 32'(bus.edge_cnt), 0);

        // Edge and forward in the same cycle, then reset in service.
        drive(6'b101000); tick();
        drive(6'b011000); tick();
        chk("same.cnt1", 32'(bus.edge_cnt), 1);
        drive(6'b001000); tick();
        drive(6'b011100); tick();
        chk("same.gate", 32'(bus.gate), 1);
        chk("same.cnt", 32'(bus.edge_cnt), 1);
        drive(6'b001110); tick();
        drive(6'b011100); tick();
        chk("rst.pre.cnt", 32'(bus.edge_cnt), 2);
        chk("rst.pre.busy", 32'(bus.busy), 1);
        drive(6'b101100); tick();
        chk("rst.gate", 32'(bus.gate), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.cnt", 32'(bus.edge_cnt), 0);
        drive(6'b001100); tick();
        chk("rst.after.gate", 32'(bus.gate), 0);
`else
        // edge_sel has no effect: behaves as level, counter stays 0.
        drive(6'b101100); tick();
        drive(6'b011100); tick();
        chk("lvl.gate", 32'(bus.gate), 1);
        chk("lvl.cnt", 32'(bus.edge_cnt), 0);
        drive(6'b001100); tick();
        chk("lvl.retract.gate", 32'(bus.gate), 0);
        chk("lvl.retract.busy", 32'(bus.busy), 0);
`endif

        // Random traffic against the reference model.
        irq = 0;
        sel = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 3) irq = ~irq;
            if ($urandom_range(0, 19) == 0) sel = ~sel;
            en  = ($urandom_range(0, 9) != 0);
            clm = ($urandom_range(0, 3) == 0);
            cmp = ($urandom_range(0, 3) == 0);
            drive({r, irq, sel, en, clm, cmp});
            tick();
            chk("rnd.gate", 32'(bus.gate), 32'(m_req));
            chk("rnd.busy", 32'(bus.busy), 32'(m_req | m_svc));
            chk("rnd.cnt", 32'(bus.edge_cnt), m_pend);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
